ycbcr_frame_ctrl: RTL and testbench
===================================

YCBCR_FRAME_CTRL -- requirements
Module: ycbcr_frame_ctrl

Interface
REQ-001 SHALL have parameter H_PIXEL, default 640: active pixels per line.
REQ-002 SHALL have parameter V_LINE, default 480: active lines per frame.
REQ-003 SHALL have parameter SKIP_FRAMES, default 10: frames discarded after enable, for camera settling.
REQ-004 SHALL have parameter PIPE_LAT, default 3: cycles from pre_wr_en to wr_en_dly in the downstream rgb_ycbcr converter.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: capture enable.
REQ-008 SHALL have port cam_vsync, input, 1 bit: camera frame sync; rising edge marks a frame boundary.
REQ-009 SHALL have port cam_href, input, 1 bit: line active.
REQ-010 SHALL have port cam_data_vld, input, 1 bit: cam_data qualifier.
REQ-011 SHALL have port cam_data, input, 16 bits: RGB565 pixel.
REQ-012 SHALL have port pre_wr_en, output, 1 bit: pixel strobe to the converter.
REQ-013 SHALL have port pix_data, output, 16 bits: pixel to the converter, valid with pre_wr_en.
REQ-014 SHALL have ports sof, eol and eof, outputs, 1 bit each: start-of-frame, end-of-line and end-of-frame markers, aligned to converter output.
REQ-015 SHALL have port frame_cnt, output, 16 bits: count of completed frames.
REQ-016 SHALL have ports line_err and frame_err, outputs, 1 bit each: sticky geometry errors.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-018 SHALL detect a vsync rise as cam_vsync=1 with its previous registered value 0.
REQ-019 SHALL implement states IDLE, SYNC, SKIP and ACTIVE.
- IDLE: go to SYNC when en=1.
- SYNC: go to SKIP on a vsync rise (to ACTIVE if SKIP_FRAMES=0).
- SKIP: count vsync rises; go to ACTIVE on the SKIP_FRAMES-th rise.
- ACTIVE: stay until a vsync rise with en=0, then go to IDLE.
REQ-020 SHALL treat en=0 in SYNC or SKIP as an immediate return to IDLE.
REQ-021 SHALL treat en=0 in ACTIVE as finish-current-frame: go to IDLE at the next vsync rise.
REQ-022 SHALL accept a pixel only when state=ACTIVE, cam_href=1, cam_data_vld=1, no vsync rise this cycle, x_cnt<H_PIXEL and y_cnt<V_LINE.
REQ-023 SHALL register pre_wr_en and pix_data one cycle after an accepted pixel; excess pixels and lines are clipped and never forwarded.
REQ-024 SHALL increment x_cnt on each accepted pixel and clear it on the href falling edge.
REQ-025 SHALL increment y_cnt on an href falling edge when the line had at least one valid pixel, saturating at V_LINE.
REQ-026 SHALL clear x_cnt and y_cnt on every vsync rise.
REQ-027 SHALL generate raw markers at acceptance:
- sof when x=0 and y=0;
- eol when x=H_PIXEL-1;
- eof when x=H_PIXEL-1 and y=V_LINE-1.
REQ-028 SHALL delay the raw markers by PIPE_LAT+1 cycles, so each is a one-cycle pulse coincident with the converter's wr_en_dly for that pixel.
REQ-029 SHALL set line_err when, at an href falling edge in ACTIVE, the line's valid-pixel count is nonzero and not equal to H_PIXEL, counting clipped pixels.
REQ-030 SHALL set frame_err when, at a vsync rise in ACTIVE, y_cnt≠V_LINE.
REQ-031 SHALL hold line_err and frame_err until reset or an IDLE→SYNC transition.
REQ-032 SHALL increment frame_cnt (wrapping 0xFFFF→0) at each vsync rise in ACTIVE with y_cnt>0.
REQ-033 SHALL, on a vsync rise coincident with a valid pixel, drop that pixel and process only the boundary.

Reset
REQ-034 SHALL, while sys_rst_n=0 at a clock edge, set:
- state=IDLE;
- all counters, including frame_cnt, to 0;
- pre_wr_en=0 and pix_data=0;
- sof, eol and eof = 0;
- line_err and frame_err = 0;
- the vsync history register and all delay-line stages to 0.
REQ-035 SHALL, on reset mid-frame, emit no marker from pixels accepted before the reset.

Structure
REQ-036 SHALL place the state encodings and parameter defaults in shared package ycbcr_ctrl_pkg.
REQ-037 SHALL implement marker alignment in one sub-module, sig_delay: a parameterised-width, parameterised-depth shift register with synchronous reset.

Verification (parameters H_PIXEL=4, V_LINE=2, SKIP_FRAMES=1, PIPE_LAT=3)
REQ-038 Bench SHALL cover these directed scenarios:
- Nominal: en=1, three frames of 2×4 pixels → frame 1 skipped; frames 2–3 give 8 pre_wr_en pulses each; sof at pixel 0, eol at pixels 3 and 7, eof at pixel 7, each 4 cycles after input; frame_cnt=2; no errors.
- Long line: a 6-pixel line → 4 forwarded, 2 clipped, line_err=1.
- Short frame: only 1 line then vsync rise → frame_err=1, no eof, frame_cnt increments.
- Enable drop: en=0 mid-frame → all 8 pixels of that frame still forwarded; IDLE after next vsync rise; busy=0.
- Reset mid-frame: reset after pixel 2 → all outputs 0 next cycle; no delayed marker emerges.
- Collision: vsync rise with cam_data_vld=1 → no pre_wr_en for that cycle.

Source files
------------

// File: rtl/ycbcr_ctrl_pkg.sv
// Shared state encoding, parameter defaults and marker payload for the
// YCbCr frame capture controller.
package ycbcr_ctrl_pkg;

    localparam int unsigned DEF_H_PIXEL     = 640;
    localparam int unsigned DEF_V_LINE      = 480;
    localparam int unsigned DEF_SKIP_FRAMES = 10;
    localparam int unsigned DEF_PIPE_LAT    = 3;

    localparam int unsigned MARK_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_SKIP   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } marker_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 32'd1) ? 32'd1 : 32'($clog2(n + 32'd1));
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with synchronous active-low reset; used to
// align frame markers with the downstream converter's output strobe.
module sig_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ycbcr_frame_ctrl.sv
// Camera capture front-end: skips settling frames, clips pixels to the
// configured geometry, forwards them to the converter and flags geometry errors.
module ycbcr_frame_ctrl
    import ycbcr_ctrl_pkg::*;
#(
    parameter int unsigned H_PIXEL     = DEF_H_PIXEL,
    parameter int unsigned V_LINE      = DEF_V_LINE,
    parameter int unsigned SKIP_FRAMES = DEF_SKIP_FRAMES,
    parameter int unsigned PIPE_LAT    = DEF_PIPE_LAT
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        en,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic        cam_data_vld,
    input  logic [15:0] cam_data,
    output logic        pre_wr_en,
    output logic [15:0] pix_data,
    output logic        sof,
    output logic        eol,
    output logic        eof,
    output logic [15:0] frame_cnt,
    output logic        line_err,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned XW = cnt_w(H_PIXEL);
    localparam int unsigned LW = cnt_w(H_PIXEL + 32'd1);
    localparam int unsigned YW = cnt_w(V_LINE);
    localparam int unsigned SW = cnt_w(SKIP_FRAMES);

    state_e        state_q, state_d;
    logic [SW-1:0] skip_cnt_q, skip_cnt_d;
    logic [XW-1:0] x_cnt_q, x_cnt_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [YW-1:0] y_cnt_q, y_cnt_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          line_err_q, line_err_d;
    logic          frame_err_q, frame_err_d;
    logic          pre_wr_en_q, pre_wr_en_d;
    logic [15:0]   pix_data_q, pix_data_d;
    logic          busy_q, busy_d;
    logic          vsync_q, href_q;

    logic          vs_rise_c, href_fall_c, vld_c, accept_c;
    marker_t       mark_raw_c, mark_dly;

    assign vs_rise_c   = cam_vsync & ~vsync_q;
    assign href_fall_c = href_q & ~cam_href;
    // A pixel that counts toward line length, whether or not it gets clipped.
    assign vld_c       = (state_q == ST_ACTIVE) & cam_href & cam_data_vld & ~vs_rise_c;
    assign accept_c    = vld_c & (x_cnt_q < XW'(H_PIXEL)) & (y_cnt_q < YW'(V_LINE));

    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        x_cnt_d     = x_cnt_q;
        line_cnt_d  = line_cnt_q;
        y_cnt_d     = y_cnt_q;
        frame_cnt_d = frame_cnt_q;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;
        pre_wr_en_d = accept_c;
        pix_data_d  = accept_c ? cam_data : pix_data_q;
        mark_raw_c  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d     = ST_SYNC;
                    line_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            ST_SYNC: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (vs_rise_c) begin
                    skip_cnt_d = '0;
                    state_d    = (SKIP_FRAMES == 32'd0) ? ST_ACTIVE : ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (vs_rise_c) begin
                    if (32'(skip_cnt_q) + 32'd1 >= SKIP_FRAMES) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        skip_cnt_d = skip_cnt_q + SW'(1);
                    end
                end
            end
            ST_ACTIVE: begin
                // Dropping enable lets the current frame finish.
                if (vs_rise_c && !en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept_c) begin
            x_cnt_d        = x_cnt_q + XW'(1);
            mark_raw_c.sof = (x_cnt_q == '0) && (y_cnt_q == '0);
            mark_raw_c.eol = (x_cnt_q == XW'(H_PIXEL - 32'd1));
            mark_raw_c.eof = mark_raw_c.eol && (y_cnt_q == YW'(V_LINE - 32'd1));
        end
        if (vld_c && (line_cnt_q != LW'(H_PIXEL + 32'd1))) begin
            line_cnt_d = line_cnt_q + LW'(1);
        end

        if (href_fall_c) begin
            x_cnt_d    = '0;
            line_cnt_d = '0;
            if ((line_cnt_q != '0) && (y_cnt_q != YW'(V_LINE))) begin
                y_cnt_d = y_cnt_q + YW'(1);
            end
            if ((state_q == ST_ACTIVE) && (line_cnt_q != '0) &&
                (line_cnt_q != LW'(H_PIXEL))) begin
                line_err_d = 1'b1;
            end
        end

        if (vs_rise_c) begin
            x_cnt_d    = '0;
            line_cnt_d = '0;
            y_cnt_d    = '0;
            if (state_q == ST_ACTIVE) begin
                if (y_cnt_q != YW'(V_LINE)) begin
                    frame_err_d = 1'b1;
                end
                if (y_cnt_q != '0) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            skip_cnt_q  <= '0;
            x_cnt_q     <= '0;
            line_cnt_q  <= '0;
            y_cnt_q     <= '0;
            frame_cnt_q <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            pre_wr_en_q <= 1'b0;
            pix_data_q  <= '0;
            busy_q      <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            x_cnt_q     <= x_cnt_d;
            line_cnt_q  <= line_cnt_d;
            y_cnt_q     <= y_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            pre_wr_en_q <= pre_wr_en_d;
            pix_data_q  <= pix_data_d;
            busy_q      <= busy_d;
            vsync_q     <= cam_vsync;
            href_q      <= cam_href;
        end
    end

    // Markers land on the same cycle as the converter's delayed write strobe.
    sig_delay #(
        .WIDTH (MARK_W),
        .DEPTH (PIPE_LAT + 32'd1)
    ) u_mark_dly (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d_i   (mark_raw_c),
        .q_o   (mark_dly)
    );

    assign pre_wr_en = pre_wr_en_q;
    assign pix_data  = pix_data_q;
    assign sof       = mark_dly.sof;
    assign eol       = mark_dly.eol;
    assign eof       = mark_dly.eof;
    assign frame_cnt = frame_cnt_q;
    assign line_err  = line_err_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ycbcr_frame_ctrl.sv
// Self-checking bench for ycbcr_frame_ctrl: a hand-derived vector table,
// directed corner sequences and randomized traffic against a behavioural model.
module tb_ycbcr_frame_ctrl;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int SK = 1;
    localparam int PL = 3;

    localparam int M_IDLE   = 0;
    localparam int M_SYNC   = 1;
    localparam int M_SKIP   = 2;
    localparam int M_ACTIVE = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic        cam_data_vld = 1'b0;
    logic [15:0] cam_data = 16'h0;
    logic        pre_wr_en;
    logic [15:0] pix_data;
    logic        sof, eol, eof;
    logic [15:0] frame_cnt;
    logic        line_err, frame_err, busy;

    always #5 sys_clk = ~sys_clk;

    ycbcr_frame_ctrl #(
        .H_PIXEL     (H),
        .V_LINE      (V),
        .SKIP_FRAMES (SK),
        .PIPE_LAT    (PL)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .en           (en),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_data_vld (cam_data_vld),
        .cam_data     (cam_data),
        .pre_wr_en    (pre_wr_en),
        .pix_data     (pix_data),
        .sof          (sof),
        .eol          (eol),
        .eof          (eof),
        .frame_cnt    (frame_cnt),
        .line_err     (line_err),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Output tallies over a scenario window.
    int t_pre, t_sof, t_eol, t_eof;

    // Behavioural reference model.
    int          m_mode, m_skipped, m_x, m_line, m_y;
    bit          m_vs_prev, m_href_prev, m_lerr, m_ferr, m_pre, m_busy;
    logic [15:0] m_pix, m_fcnt;
    bit   [2:0]  m_mark;
    bit   [2:0]  m_pipe[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_skipped = 0; m_x = 0; m_line = 0; m_y = 0;
        m_vs_prev = 0; m_href_prev = 0; m_lerr = 0; m_ferr = 0;
        m_pre = 0; m_busy = 0; m_pix = '0; m_fcnt = '0; m_mark = '0;
        m_pipe.delete();
        // Markers trail pre_wr_en by the converter latency.
        for (int i = 0; i < PL; i++) m_pipe.push_back(3'b000);
    endtask

    task automatic model_update(input bit r, input bit e, input bit vs, input bit hr,
                                input bit vl, input logic [15:0] d);
        bit rise, fall, seen, take;
        bit [2:0] mk;
        if (!r) begin
            model_reset();
            return;
        end
        rise = vs && !m_vs_prev;
        fall = m_href_prev && !hr;
        seen = (m_mode == M_ACTIVE) && hr && vl && !rise;
        take = seen && (m_x < H) && (m_y < V);
        mk = '0;
        if (take) mk = {(m_x == 0) && (m_y == 0), m_x == H - 1, (m_x == H - 1) && (m_y == V - 1)};
        m_pipe.push_back(mk);
        m_mark = m_pipe.pop_front();
        m_pre = take;
        if (take) m_pix = d;
        if (rise && m_mode == M_ACTIVE) begin
            if (m_y != V) m_ferr = 1;
            if (m_y > 0) m_fcnt = m_fcnt + 16'd1;
        end
        if (fall && m_mode == M_ACTIVE && m_line > 0 && m_line != H) m_lerr = 1;
        if (rise) begin
            m_x = 0; m_y = 0; m_line = 0;
        end else if (fall) begin
            if (m_line > 0 && m_y < V) m_y++;
            m_x = 0; m_line = 0;
        end else begin
            if (take) m_x++;
            if (seen) m_line++;
        end
        case (m_mode)
            M_IDLE: if (e) begin m_mode = M_SYNC; m_lerr = 0; m_ferr = 0; end
            M_SYNC: if (!e) m_mode = M_IDLE;
                    else if (rise) begin m_skipped = 0; m_mode = (SK == 0) ? M_ACTIVE : M_SKIP; end
            M_SKIP: if (!e) m_mode = M_IDLE;
                    else if (rise) begin m_skipped++; if (m_skipped >= SK) m_mode = M_ACTIVE; end
            default: if (rise && !e) m_mode = M_IDLE;
        endcase
        m_vs_prev = vs;
        m_href_prev = hr;
        m_busy = (m_mode != M_IDLE);
    endtask

    task automatic check_model();
        chk("pre_wr_en", 32'(pre_wr_en), 32'(m_pre));
        chk("pix_data",  32'(pix_data),  32'(m_pix));
        chk("sof",       32'(sof),       32'(m_mark[2]));
        chk("eol",       32'(eol),       32'(m_mark[1]));
        chk("eof",       32'(eof),       32'(m_mark[0]));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        chk("line_err",  32'(line_err),  32'(m_lerr));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("busy",      32'(busy),      32'(m_busy));
    endtask

    task automatic step(input bit r, input bit e, input bit vs, input bit hr,
                        input bit vl, input logic [15:0] d);
        sys_rst_n = r; en = e; cam_vsync = vs; cam_href = hr; cam_data_vld = vl; cam_data = d;
        @(posedge sys_clk);
        model_update(r, e, vs, hr, vl, d);
        #1;
        check_model();
        if (pre_wr_en) t_pre++;
        if (sof) t_sof++;
        if (eol) t_eol++;
        if (eof) t_eof++;
    endtask

    task automatic clr_tally();
        t_pre = 0; t_sof = 0; t_eol = 0; t_eof = 0;
    endtask

    task automatic idle(input bit e, input int n);
        repeat (n) step(1, e, 0, 0, 0, 16'h0);
    endtask

    task automatic vs_pulse(input bit e);
        step(1, e, 1, 0, 0, 16'h0);
        step(1, e, 0, 0, 0, 16'h0);
    endtask

    task automatic send_line(input bit e, input int n);
        for (int i = 0; i < n; i++) step(1, e, 0, 1, 1, 16'($urandom));
        step(1, e, 0, 0, 0, 16'h0);
    endtask

    task automatic send_frame(input bit e);
        send_line(e, H);
        send_line(e, H);
    endtask

    // Reset, enable, skip one settling frame, arrive in ACTIVE at a frame start.
    task automatic go_active();
        step(0, 0, 0, 0, 0, 16'h0);
        step(1, 1, 0, 0, 0, 16'h0);
        vs_pulse(1);
        send_frame(1);
        vs_pulse(1);
    endtask

    typedef struct {
        bit          rst, en, vs, href, vld;
        logic [15:0] d;
        bit          pre, sof, eol, eof, busy;
        logic [15:0] pix;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{0,0,0,0,0,16'h0000, 0,0,0,0,0,16'h0000};
        tbl[1]  = '{1,1,0,0,0,16'h0000, 0,0,0,0,1,16'h0000};
        tbl[2]  = '{1,1,1,0,0,16'h0000, 0,0,0,0,1,16'h0000};
        tbl[3]  = '{1,1,0,0,0,16'h0000, 0,0,0,0,1,16'h0000};
        tbl[4]  = '{1,1,1,0,0,16'h0000, 0,0,0,0,1,16'h0000};
        tbl[5]  = '{1,1,0,0,0,16'h0000, 0,0,0,0,1,16'h0000};
        tbl[6]  = '{1,1,0,1,1,16'hA000, 1,0,0,0,1,16'hA000};
        tbl[7]  = '{1,1,0,1,1,16'hA001, 1,0,0,0,1,16'hA001};
        tbl[8]  = '{1,1,0,1,1,16'hA002, 1,0,0,0,1,16'hA002};
        tbl[9]  = '{1,1,0,1,1,16'hA003, 1,1,0,0,1,16'hA003};
        tbl[10] = '{1,1,0,0,0,16'h0000, 0,0,0,0,1,16'hA003};
        tbl[11] = '{1,1,0,0,0,16'h0000, 0,0,0,0,1,16'hA003};
        tbl[12] = '{1,1,0,0,0,16'h0000, 0,0,1,0,1,16'hA003};
        tbl[13] = '{1,1,0,0,0,16'h0000, 0,0,0,0,1,16'hA003};

        clr_tally();
        model_reset();

        // Startup and first line, hand-derived expectations.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].vs, tbl[i].href, tbl[i].vld, tbl[i].d);
            chk($sformatf("tbl%0d.pre", i),  32'(pre_wr_en), 32'(tbl[i].pre));
            chk($sformatf("tbl%0d.sof", i),  32'(sof),       32'(tbl[i].sof));
            chk($sformatf("tbl%0d.eol", i),  32'(eol),       32'(tbl[i].eol));
            chk($sformatf("tbl%0d.eof", i),  32'(eof),       32'(tbl[i].eof));
            chk($sformatf("tbl%0d.busy", i), 32'(busy),      32'(tbl[i].busy));
            chk($sformatf("tbl%0d.pix", i),  32'(pix_data),  32'(tbl[i].pix));
        end

        // Nominal: two captured frames after the skipped one.
        go_active();
        for (int f = 0; f < 2; f++) begin
            clr_tally();
            send_frame(1);
            vs_pulse(1);
            idle(1, 4);
            chk("nom.pre_cnt", 32'(t_pre), 32'd8);
            chk("nom.sof_cnt", 32'(t_sof), 32'd1);
            chk("nom.eol_cnt", 32'(t_eol), 32'd2);
            chk("nom.eof_cnt", 32'(t_eof), 32'd1);
        end
        chk("nom.frame_cnt", 32'(frame_cnt), 32'd2);
        chk("nom.line_err",  32'(line_err),  32'd0);
        chk("nom.frame_err", 32'(frame_err), 32'd0);

        // Long line: clipped to H pixels and flagged.
        clr_tally();
        send_line(1, 6);
        idle(1, 4);
        chk("long.pre_cnt",  32'(t_pre),    32'd4);
        chk("long.line_err", 32'(line_err), 32'd1);

        // Short frame: one line only.
        go_active();
        clr_tally();
        send_line(1, H);
        vs_pulse(1);
        idle(1, 4);
        chk("short.frame_err", 32'(frame_err), 32'd1);
        chk("short.eof_cnt",   32'(t_eof),     32'd0);
        chk("short.frame_cnt", 32'(frame_cnt), 32'd1);

        // Enable drop mid-frame: frame completes, then IDLE.
        go_active();
        clr_tally();
        send_line(1, H);
        send_line(0, H);
        idle(0, 2);
        chk("endrop.busy_mid", 32'(busy), 32'd1);
        vs_pulse(0);
        idle(0, 4);
        chk("endrop.pre_cnt",  32'(t_pre),     32'd8);
        chk("endrop.eof_cnt",  32'(t_eof),     32'd1);
        chk("endrop.busy",     32'(busy),      32'd0);
        chk("endrop.frame_cnt", 32'(frame_cnt), 32'd1);

        // Reset after pixel 2 of a frame.
        go_active();
        clr_tally();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 1, 16'($urandom));
        step(0, 1, 0, 1, 1, 16'h1234);
        chk("rst.pre",  32'(pre_wr_en), 32'd0);
        chk("rst.pix",  32'(pix_data),  32'd0);
        chk("rst.sof",  32'(sof),       32'd0);
        chk("rst.busy", 32'(busy),      32'd0);
        clr_tally();
        idle(0, 6);
        chk("rst.late_markers", 32'(t_sof + t_eol + t_eof), 32'd0);

        // vsync rise coinciding with a valid pixel.
        go_active();
        step(1, 1, 0, 1, 1, 16'h0101);
        step(1, 1, 0, 1, 1, 16'h0202);
        step(1, 1, 1, 1, 1, 16'h0303);
        chk("coll.pre", 32'(pre_wr_en), 32'd0);
        step(1, 1, 0, 1, 1, 16'h0404);
        chk("coll.next_pre", 32'(pre_wr_en), 32'd1);
        step(1, 1, 0, 0, 0, 16'h0);
        idle(1, 4);

        // Randomized traffic against the model.
        begin
            bit e, vs, hr, vl, r;
            e = 1; vs = 0; hr = 0;
            step(0, 0, 0, 0, 0, 16'h0);
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 199) == 0) e = !e;
                vs = ($urandom_range(0, 59) == 0) ? 1'b1 : (vs && ($urandom_range(0, 1) == 1));
                if ($urandom_range(0, 4) == 0) hr = !hr;
                vl = ($urandom_range(0, 9) < 8);
                r = ($urandom_range(0, 999) != 0);
                step(r, e, vs, hr, vl, 16'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
